alu_implementation: RTL and testbench

4-bit registered arithmetic/logic unit with status flags (zero, negative, overflow, carry). Combines two operands under an opcode and registers the result and flags on the clock edge. Used as a leaf datapath block: an upstream source drives operands and opcode; the registered result and flags feed downstream logic or a monitor.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_adder.sv | 26 ++
 rtl/alu_implementation.sv | 103 ++++++++++
 tb/tb_alu_implementation.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: default width, opcode type and opcode constants.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 4;
  localparam int unsigned OP_W      = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD = 3'b000;
  localparam op_t OP_SUB = 3'b001;
  localparam op_t OP_AND = 3'b010;
  localparam op_t OP_OR  = 3'b011;
  localparam op_t OP_XOR = 3'b100;
  localparam op_t OP_NOT = 3'b101;
  localparam op_t OP_SHL = 3'b110;
  localparam op_t OP_SHR = 3'b111;

endpackage : alu_pkg

// File: rtl/alu_adder.sv
// Ripple-carry adder built from full-adder cells.
// It also exposes the carry into the MSB so the caller can derive signed overflow.
module alu_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[WIDTH];
  assign c_msb = c[WIDTH-1];

endmodule : alu_adder

// File: rtl/alu_implementation.sv
// Registered ALU: opcode mux and flag logic feed one output register stage.
// The output register stage is cleared asynchronously by rst_n.
module alu_implementation
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  op_t              op,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  output logic             negf,
  output logic             zf,
  output logic             carf
);

  logic             is_sub;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  logic             add_cmsb;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             ovf_d, ovf_q;
  logic             negf_d, negf_q;
  logic             zf_d, zf_q;
  logic             carf_d, carf_q;

  // SUB reuses the adder as A + ~B + 1.
  assign is_sub = (op == OP_SUB);
  assign add_b  = is_sub ? ~B : B;

  alu_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a     (A),
    .b     (add_b),
    .cin   (is_sub),
    .s     (add_s),
    .cout  (add_cout),
    .c_msb (add_cmsb)
  );

  always_comb begin
    sum_d  = '0;
    ovf_d  = 1'b0;
    carf_d = 1'b0;
    case (op)
      OP_ADD: begin
        sum_d  = add_s;
        carf_d = add_cout;
        ovf_d  = add_cout ^ add_cmsb;
      end
      OP_SUB: begin
        sum_d  = add_s;
        carf_d = ~add_cout;
        ovf_d  = add_cout ^ add_cmsb;
      end
      OP_AND: sum_d = A & B;
      OP_OR:  sum_d = A | B;
      OP_XOR: sum_d = A ^ B;
      OP_NOT: sum_d = ~A;
      OP_SHL: begin
        sum_d  = {A[WIDTH-2:0], 1'b0};
        carf_d = A[WIDTH-1];
        ovf_d  = A[WIDTH-1] ^ A[WIDTH-2];
      end
      OP_SHR: begin
        sum_d  = {1'b0, A[WIDTH-1:1]};
        carf_d = A[0];
      end
      default: sum_d = '0;
    endcase
    zf_d   = (sum_d == '0);
    negf_d = sum_d[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      ovf_q  <= 1'b0;
      negf_q <= 1'b0;
      zf_q   <= 1'b1;
      carf_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      ovf_q  <= ovf_d;
      negf_q <= negf_d;
      zf_q   <= zf_d;
      carf_q <= carf_d;
    end
  end

  assign sum  = sum_q;
  assign ovf  = ovf_q;
  assign negf = negf_q;
  assign zf   = zf_q;
  assign carf = carf_q;

endmodule : alu_implementation

// File: tb/tb_alu_implementation.sv
// Self-checking bench for alu_implementation: directed vector table, random ops against an
// arithmetic reference model, and reset/latency sequences.
module tb_alu_implementation;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] A, B;
  logic [2:0] op;
  logic [3:0] sum;
  logic       ovf, negf, zf, carf;

  int n_cmp = 0;
  int n_fail = 0;

  // Expected word layout: {sum[3:0], zf, negf, ovf, carf}
  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  localparam int unsigned NVEC = 13;
  vec_t vecs [NVEC];

  alu_implementation #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .op   (op),
    .sum  (sum),
    .ovf  (ovf),
    .negf (negf),
    .zf   (zf),
    .carf (carf)
  );

  always #5 clk = ~clk;

  // Reference model from signed/unsigned integer arithmetic.
  function automatic logic [7:0] model(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
    int ua, ub, sa, sb, res, sres;
    logic c, v;
    logic [3:0] r;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    c = 1'b0;
    v = 1'b0;
    res = 0;
    case (o)
      3'd0: begin res = ua + ub; c = (res > 15); sres = sa + sb; v = (sres < -8) || (sres > 7); end
      3'd1: begin res = ua - ub; c = (ua < ub);  sres = sa - sb; v = (sres < -8) || (sres > 7); end
      3'd2: res = ua & ub;
      3'd3: res = ua | ub;
      3'd4: res = ua ^ ub;
      3'd5: res = 15 - ua;
      3'd6: begin res = ua * 2; c = (ua >= 8); sres = sa * 2; v = (sres < -8) || (sres > 7); end
      default: begin res = ua / 2; c = (ua % 2) == 1; end
    endcase
    r = 4'(res);
    return {r, (r == 4'd0), r[3], v, c};
  endfunction

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {sum, zf, negf, ovf, carf};
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {sum,zf,negf,ovf,carf}=%b_%b%b%b%b required %b_%b%b%b%b",
               name, act[7:4], act[3], act[2], act[1], act[0],
               exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive inputs just after an edge, then sample just after the capturing edge.
  task automatic apply(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
    op = o;
    A  = a;
    B  = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{3'b000, 4'b0110, 4'b0010, 8'b1000_0110};
    vecs[1]  = '{3'b000, 4'b1111, 4'b0001, 8'b0000_1001};
    vecs[2]  = '{3'b001, 4'b0011, 4'b0101, 8'b1110_0101};
    vecs[3]  = '{3'b001, 4'b1000, 4'b0001, 8'b0111_0010};
    vecs[4]  = '{3'b010, 4'b1010, 4'b0110, 8'b0010_0000};
    vecs[5]  = '{3'b011, 4'b1010, 4'b0110, 8'b1110_0100};
    vecs[6]  = '{3'b100, 4'b1010, 4'b0110, 8'b1100_0100};
    vecs[7]  = '{3'b101, 4'b1010, 4'b0110, 8'b0101_0000};
    vecs[8]  = '{3'b110, 4'b1010, 4'b0110, 8'b0100_0011};
    vecs[9]  = '{3'b111, 4'b1010, 4'b0110, 8'b0101_0000};
    vecs[10] = '{3'b000, 4'b0000, 4'b0000, 8'b0000_1000};
    vecs[11] = '{3'b001, 4'b0101, 4'b0101, 8'b0000_1000};
    vecs[12] = '{3'b111, 4'b0001, 4'b0000, 8'b0000_1001};

    // Reset held low with arbitrary inputs
    rst_n = 1'b0;
    op = 3'b000; A = 4'b0111; B = 4'b0111;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 8'b0000_1000);
    rst_n = 1'b1;
    apply(3'b000, 4'b0110, 4'b0010);
    check("first_capture", 8'b1000_0110);

    for (int i = 0; i < int'(NVEC); i++) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Constant inputs give constant outputs
    for (int i = 0; i < 3; i++) begin
      apply(3'b001, 4'b0011, 4'b0101);
      check($sformatf("const%0d", i), 8'b1110_0101);
    end

    // Back-to-back random ops, one-cycle latency
    for (int i = 0; i < 200; i++) begin
      logic [2:0] o;
      logic [3:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = 4'($urandom);
      b = 4'($urandom);
      apply(o, a, b);
      check($sformatf("rand%0d_op%0d_a%0d_b%0d", i, o, a, b), model(o, a, b));
    end

    // Mid-stream async reset clears outputs between edges
    apply(3'b000, 4'b0110, 4'b0010);
    check("pre_reset", 8'b1000_0110);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_clear", 8'b0000_1000);
    op = 3'b101; A = 4'b0000;
    @(posedge clk);
    #1;
    check("reset_discard", 8'b0000_1000);
    rst_n = 1'b1;
    apply(3'b101, 4'b0000, 4'b0000);
    check("post_reset_capture", 8'b1111_0100);
    apply(3'b110, 4'b0100, 4'b0000);
    check("post_reset_shl", 8'b1000_0110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_alu_implementation
